// File: rtl/mem_arbiter_if.sv
// Request, response and shared-RAM signals between the pipeline, the arbiter and the RAM.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
);
  logic              start_i;
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_ack_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              mem_req_i;
  logic              mem_we_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_wdata_i;
  logic              mem_ack_o;
  logic [DATA_W-1:0] mem_rdata_o;
  logic              ram_en_o;
  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [DATA_W-1:0] ram_wdata_o;
  logic [DATA_W-1:0] ram_rdata_i;
  logic              ram_ready_i;
  logic              stall_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  // Arbiter side
  modport slave (
    input  start_i, if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i,
    input  ram_rdata_i, ram_ready_i,
    output if_ack_o, if_rdata_o, mem_ack_o, mem_rdata_o,
    output ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, stall_o, stall_cnt_o
  );

  // Pipeline / RAM side
  modport master (
    output start_i, if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i,
    output ram_rdata_i, ram_ready_i,
    input  if_ack_o, if_rdata_o, mem_ack_o, mem_rdata_o,
    input  ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, stall_o, stall_cnt_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and MEM-stage requests onto one single-port RAM with a variable-latency handshake.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MEM_BUSY, IF_BUSY, RESP} state_t;

  state_t            state_q, state_d;
  logic              last_mem_q, last_mem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic              if_ack_q, if_ack_d;
  logic              mem_ack_q, mem_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stall;
  logic              grant_mem;

  // Pipeline stall request, cleared in the cycle the requester is acknowledged
  assign stall = (bus.if_req_i & ~if_ack_q) | (bus.mem_req_i & ~mem_ack_q);

  // MEM wins a tie unless it also won the previous grant
  assign grant_mem = bus.mem_req_i & ~(bus.if_req_i & last_mem_q);

  // Next-state, latch and output decode
  always_comb begin
    state_d     = state_q;
    last_mem_d  = last_mem_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    cnt_d       = cnt_q;

    if (bus.start_i && stall && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          if (grant_mem) begin
            state_d    = MEM_BUSY;
            last_mem_d = 1'b1;
            addr_d     = bus.mem_addr_i;
            wdata_d    = bus.mem_wdata_i;
            we_d       = bus.mem_we_i;
            ram_en_d   = 1'b1;
            ram_we_d   = bus.mem_we_i;
          end else if (bus.if_req_i) begin
            state_d    = IF_BUSY;
            last_mem_d = 1'b0;
            addr_d     = bus.if_addr_i;
            wdata_d    = '0;
            we_d       = 1'b0;
            ram_en_d   = 1'b1;
          end
        end
      end
      MEM_BUSY, IF_BUSY: begin
        if (bus.ram_ready_i) begin
          state_d = RESP;
          if (state_q == IF_BUSY) begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus.ram_rdata_i;
          end else begin
            mem_ack_d = 1'b1;
            if (!we_q) begin
              mem_rdata_d = bus.ram_rdata_i;
            end
          end
        end else begin
          ram_en_d = 1'b1;
          ram_we_d = we_q;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears everything at once
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      last_mem_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_mem_q  <= last_mem_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.if_ack_o    = if_ack_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.mem_ack_o   = mem_ack_q;
  assign bus.mem_rdata_o = mem_rdata_q;
  assign bus.ram_en_o    = ram_en_q;
  assign bus.ram_we_o    = ram_we_q;
  assign bus.ram_addr_o  = addr_q;
  assign bus.ram_wdata_o = wdata_q;
  assign bus.stall_o     = stall;
  assign bus.stall_cnt_o = cnt_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter CNT_W, default 32, stall counter width.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start_i  input  1  enables new grants when high.
REQ-007 SHALL have port if_req_i  input  1  fetch-stage read request, held until if_ack_o.
REQ-008 SHALL have port if_addr_i  input  ADDR_W  fetch address.
REQ-009 SHALL have port if_ack_o  output  1  one-cycle fetch completion pulse.
REQ-010 SHALL have port if_rdata_o  output  DATA_W  fetched word, valid while if_ack_o is high.
REQ-011 SHALL have port mem_req_i  input  1  MEM-stage request, held until mem_ack_o.
REQ-012 SHALL have port mem_we_i  input  1  1 = store, 0 = load.
REQ-013 SHALL have port mem_addr_i  input  ADDR_W  load/store address.
REQ-014 SHALL have port mem_wdata_i  input  DATA_W  store data.
REQ-015 SHALL have port mem_ack_o  output  1  one-cycle MEM completion pulse.
REQ-016 SHALL have port mem_rdata_o  output  DATA_W  load data, valid while mem_ack_o is high after a load.
REQ-017 SHALL have port ram_en_o  output  1  shared single-port RAM access strobe.
REQ-018 SHALL have port ram_we_o  output  1  RAM write enable.
REQ-019 SHALL have port ram_addr_o  output  ADDR_W  RAM address.
REQ-020 SHALL have port ram_wdata_o  output  DATA_W  RAM write data.
REQ-021 SHALL have port ram_rdata_i  input  DATA_W  RAM read data, valid with ram_ready_i.
REQ-022 SHALL have port ram_ready_i  input  1  RAM access complete, variable latency of 1 cycle or more.
REQ-023 SHALL have port stall_o  output  1  pipeline stall request.
REQ-024 SHALL have port stall_cnt_o  output  CNT_W  count of stalled cycles.

Function
REQ-025 SHALL implement the FSM states IDLE, MEM_BUSY, IF_BUSY and RESP.
REQ-026 In IDLE with start_i=1, SHALL go to MEM_BUSY if mem_req_i=1, else to IF_BUSY if if_req_i=1; with start_i=0, SHALL stay in IDLE.
REQ-027 Tie-break (both requests in IDLE): MEM wins, unless the previous grant was MEM, in which case IF wins; a last_grant register SHALL be updated on each grant.
REQ-028 On grant, SHALL latch address, write data and we; the RAM outputs SHALL come from these latches only, never from live request inputs.
REQ-029 In MEM_BUSY/IF_BUSY, SHALL hold ram_en_o=1 and keep ram_we_o = latched mem_we (always 0 in IF_BUSY).
REQ-030 In MEM_BUSY/IF_BUSY with ram_ready_i=1, SHALL capture ram_rdata_i (loads/fetches only) and go to RESP; otherwise SHALL stay.
REQ-031 In RESP, SHALL assert exactly one of if_ack_o/mem_ack_o for one cycle, with ram_en_o=0, then go to IDLE.
REQ-032 Minimum request-to-ack latency: request seen in IDLE at cycle N, ram_en_o at N+1, ram_ready_i at N+1, ack at N+2.
REQ-033 A store SHALL leave mem_rdata_o unchanged; if_rdata_o/mem_rdata_o SHALL hold their last captured value between acks.
REQ-034 start_i falling during MEM_BUSY/IF_BUSY SHALL NOT abort the access: it completes through RESP, then the FSM holds in IDLE.
REQ-035 SHALL combinationally drive stall_o = (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o).
REQ-036 SHALL increment stall_cnt_o by 1 on each rising edge with start_i=1 and stall_o=1, saturating at all-ones with no wrap.
REQ-037 SHALL ignore ram_ready_i in IDLE and RESP.

Reset
REQ-038 With rst_i=0, SHALL immediately and asynchronously enter IDLE and set all outputs and latches to 0, including ram_en_o, stall_cnt_o and last_grant (=IF).
REQ-039 Reset asserted mid-access SHALL drop ram_en_o at once and give no ack; after release, a still-pending request SHALL be re-arbitrated from IDLE.

Verification
REQ-040 Single fetch: if_req_i=1, if_addr_i=0x10, ram_ready_i pulses in the first BUSY cycle, ram_rdata_i=0x8C020000 -> ram_addr_o=0x10, if_ack_o pulses 2 cycles after the request with if_rdata_o=0x8C020000, and stall_cnt_o=2.
REQ-041 Simultaneous requests repeated 3 times, ram_ready_i immediate -> grant order MEM, IF, MEM, IF, MEM, IF, with no more than one ack per RESP.
REQ-042 Store mem_we_i=1, addr 0x04, wdata 5, ram_ready_i delayed 3 cycles -> ram_we_o=1 for exactly 3 cycles, mem_ack_o pulses once, mem_rdata_o is unchanged.
REQ-043 rst_i driven low in the second MEM_BUSY cycle -> ram_en_o=0 within the same cycle, no ack, stall_cnt_o=0; after release the pending request completes normally.
REQ-044 start_i=0 with if_req_i=1 for 5 cycles -> no grant, ram_en_o=0, stall_o=1, stall_cnt_o unchanged.
REQ-045 stall_cnt_o preloaded near saturation (CNT_W=4, value 14) with 3 further stall cycles -> stall_cnt_o ends at 15 and does not wrap.
